// File: rtl/cpu_params_pkg.sv
// Shared CPU constants for the interrupt controller: privilege mode
// encodings, standard interrupt cause codes and the controller FSM states.
package cpu_params_pkg;

    localparam logic [1:0] M_MODE = 2'd3;
    localparam logic [1:0] S_MODE = 2'd1;
    localparam logic [1:0] U_MODE = 2'd0;

    localparam int unsigned CAUSE_MSI  = 32'd3;
    localparam int unsigned CAUSE_MTI  = 32'd7;
    localparam int unsigned CAUSE_MEI  = 32'd11;
    localparam int unsigned CAUSE_SSI  = 32'd1;
    localparam int unsigned CAUSE_STI  = 32'd5;
    localparam int unsigned CAUSE_SEI  = 32'd9;
    localparam int unsigned LIRQ_BASE  = 32'd16;

    // Widest cause space supported (16 standard + 48 local lines).
    localparam int unsigned MAX_CAUSES = 32'd64;
    localparam int unsigned PICK_W     = 32'd6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OFFER  = 2'd1,
        SETTLE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/functions_pkg.sv
// Helper functions for the interrupt controller. prio_pick returns the
// highest-priority set bit of a request vector padded to MAX_CAUSES bits.
package functions_pkg;

    import cpu_params_pkg::*;

    typedef struct packed {
        logic              found;
        logic [PICK_W-1:0] cause;
    } pick_t;

    // Priority: 11 > 3 > 7 > 9 > 1 > 5 > local lines (lowest index first).
    // Written as ascending-priority overrides so the last hit wins.
    function automatic pick_t prio_pick(input logic [MAX_CAUSES-1:0] req);
        pick_t p;
        p.found = 1'b0;
        p.cause = 6'd0;
        for (int i = MAX_CAUSES - 1; i >= int'(LIRQ_BASE); i--) begin
            if (req[i]) begin
                p.found = 1'b1;
                p.cause = 6'(i);
            end
        end
        if (req[CAUSE_STI]) begin p.found = 1'b1; p.cause = 6'(CAUSE_STI); end
        if (req[CAUSE_SSI]) begin p.found = 1'b1; p.cause = 6'(CAUSE_SSI); end
        if (req[CAUSE_SEI]) begin p.found = 1'b1; p.cause = 6'(CAUSE_SEI); end
        if (req[CAUSE_MTI]) begin p.found = 1'b1; p.cause = 6'(CAUSE_MTI); end
        if (req[CAUSE_MSI]) begin p.found = 1'b1; p.cause = 6'(CAUSE_MSI); end
        if (req[CAUSE_MEI]) begin p.found = 1'b1; p.cause = 6'(CAUSE_MEI); end
        return p;
    endfunction

endpackage

// File: rtl/lirq_sync_edge.sv
// One local interrupt line: synchroniser, optional rising-edge detector
// and pending latch.
//   clk_in, reset_in : clock, asynchronous active-low reset
//   lirq_in          : raw asynchronous line
//   clr              : CSR clear of the latched pending bit (edge lines only)
//   claim            : this line's cause was just accepted (edge lines only)
//   pending          : pending view (latched for edge, synchronised level otherwise)
module lirq_sync_edge #(
    parameter bit EDGE        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic reset_in,
    input  logic lirq_in,
    input  logic clr,
    input  logic claim,
    output logic pending
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_s;

    // Synchroniser shift chain for the asynchronous line.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], lirq_in};
        end
    end

    assign sync_s = sync_r[SYNC_STAGES-1];

    generate
        if (EDGE) begin : g_edge
            logic prev_r;
            logic pend_r;

            // Edge detect and pending latch; a new edge beats a same-cycle clear.
            always_ff @(posedge clk_in or negedge reset_in) begin
                if (!reset_in) begin
                    prev_r <= 1'b0;
                    pend_r <= 1'b0;
                end else begin
                    prev_r <= sync_s;
                    if (sync_s && !prev_r) begin
                        pend_r <= 1'b1;
                    end else if (clr || claim) begin
                        pend_r <= 1'b0;
                    end else begin
                        pend_r <= pend_r;
                    end
                end
            end

            assign pending = pend_r;
        end else begin : g_level
            // Level lines simply follow the synchronised input; clears are ignored.
            logic unused_s;
            assign unused_s = clr ^ claim;
            assign pending  = sync_s;
        end
    endgenerate

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: merges standard M/S sources with local lines,
// applies enable/delegation/global-enable rules, picks by fixed priority
// and offers one registered request to WB over a valid/ready handshake.
//   clk_in, reset_in             : clock, asynchronous active-low reset
//   mode, mstatus_mie/sie        : current privilege and global enables
//   mip_std, mie, mideleg        : standard pending, enables, delegation
//   mtvec, stvec                 : trap vectors
//   lirq_in, lirq_clr            : local lines and edge-pending clears
//   irq_block                    : suppresses new offers
//   irq_valid/irq_ready          : handshake to WB
//   irq_cause, irq_to_s, trap_pc : offered request
//   lirq_pending                 : local pending view for mip readout
module irq_ctrl
    import cpu_params_pkg::*;
    import functions_pkg::*;
#(
    parameter int                NUM_LIRQ    = 16,
    parameter logic [NUM_LIRQ-1:0] EDGE_MASK = '0,
    parameter int                SYNC_STAGES = 2,
    parameter int                CAUSE_W     = $clog2(16 + NUM_LIRQ),
    parameter int                RSZ         = 32,
    parameter int                PC_SZ       = 32
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic [1:0]             mode,
    input  logic                   mstatus_mie,
    input  logic                   mstatus_sie,
    input  logic [11:0]            mip_std,
    input  logic [16+NUM_LIRQ-1:0] mie,
    input  logic [16+NUM_LIRQ-1:0] mideleg,
    input  logic [RSZ-1:0]         mtvec,
    input  logic [RSZ-1:0]         stvec,
    input  logic [NUM_LIRQ-1:0]    lirq_in,
    input  logic [NUM_LIRQ-1:0]    lirq_clr,
    input  logic                   irq_block,
    output logic                   irq_valid,
    input  logic                   irq_ready,
    output logic [CAUSE_W-1:0]     irq_cause,
    output logic                   irq_to_s,
    output logic [PC_SZ-1:0]       trap_pc,
    output logic [NUM_LIRQ-1:0]    lirq_pending
);

    localparam int NC = 16 + NUM_LIRQ;

    irq_state_t              state_r, state_nx;
    logic                    valid_r;
    logic [PICK_W-1:0]       cause_r;
    logic                    to_s_r;
    logic [PC_SZ-1:0]        pc_r;

    logic [NC-1:0]           p_s, e_s;
    logic [MAX_CAUSES-1:0]   e_pad_s, deleg_pad_s;
    logic                    m_gie_s, s_gie_s;
    pick_t                   pick_m_s, pick_s_s;
    logic                    cand_found_s, cand_to_s_s;
    logic [PICK_W-1:0]       cand_cause_s;
    logic [RSZ-1:0]          tvec_s, base_s, pc_full_s;
    logic                    offer_live_s, load_s, claim_s;
    logic [NUM_LIRQ-1:0]     claim_lirq_s;

    generate
        for (genvar i = 0; i < NUM_LIRQ; i++) begin : g_lirq
            assign claim_lirq_s[i] = claim_s && (cause_r == 6'(int'(LIRQ_BASE) + i));
            lirq_sync_edge #(
                .EDGE        (EDGE_MASK[i]),
                .SYNC_STAGES (SYNC_STAGES)
            ) u_line (
                .clk_in   (clk_in),
                .reset_in (reset_in),
                .lirq_in  (lirq_in[i]),
                .clr      (lirq_clr[i]),
                .claim    (claim_lirq_s[i]),
                .pending  (lirq_pending[i])
            );
        end
    endgenerate

    // Pending/enable vectors, global enables, arbitration and handler address.
    always_comb begin
        p_s         = '0;
        p_s[11:0]   = mip_std;
        p_s[NC-1:16] = lirq_pending;
        e_s         = p_s & mie;
        e_pad_s     = '0;
        e_pad_s[NC-1:0] = e_s;
        deleg_pad_s = '0;
        if (mode != M_MODE) begin
            deleg_pad_s[NC-1:0] = mideleg;
        end else begin
            deleg_pad_s[NC-1:0] = '0;
        end
        m_gie_s = (mode != M_MODE) || mstatus_mie;
        s_gie_s = (mode == U_MODE) || ((mode == S_MODE) && mstatus_sie);

        // Any M-target outranks every S-target, so arbitrate them separately.
        pick_m_s = prio_pick(e_pad_s & ~deleg_pad_s & {MAX_CAUSES{m_gie_s}});
        pick_s_s = prio_pick(e_pad_s &  deleg_pad_s & {MAX_CAUSES{s_gie_s}});
        cand_found_s = pick_m_s.found || pick_s_s.found;
        if (pick_m_s.found) begin
            cand_cause_s = pick_m_s.cause;
            cand_to_s_s  = 1'b0;
        end else begin
            cand_cause_s = pick_s_s.cause;
            cand_to_s_s  = 1'b1;
        end

        tvec_s = cand_to_s_s ? stvec : mtvec;
        base_s = {tvec_s[RSZ-1:2], 2'b00};
        if (tvec_s[1:0] == 2'b01) begin
            pc_full_s = base_s + {{(RSZ-PICK_W-2){1'b0}}, cand_cause_s, 2'b00};
        end else begin
            pc_full_s = base_s;
        end

        // The offered cause stays live while enabled and its target globally enabled.
        offer_live_s = e_pad_s[cause_r] && (to_s_r ? s_gie_s : m_gie_s);
    end

    // Next-state logic for the offer handshake.
    always_comb begin
        state_nx = state_r;
        load_s   = 1'b0;
        claim_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (cand_found_s && !irq_block) begin
                    load_s   = 1'b1;
                    state_nx = OFFER;
                end else begin
                    state_nx = IDLE;
                end
            end
            OFFER: begin
                if (irq_ready) begin
                    claim_s  = 1'b1;
                    state_nx = SETTLE;
                end else if (!offer_live_s) begin
                    state_nx = IDLE;
                end else begin
                    state_nx = OFFER;
                end
            end
            SETTLE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State and registered request outputs; request fields held while offered.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_r <= IDLE;
            valid_r <= 1'b0;
            cause_r <= '0;
            to_s_r  <= 1'b0;
            pc_r    <= '0;
        end else begin
            state_r <= state_nx;
            valid_r <= (state_nx == OFFER);
            if (load_s) begin
                cause_r <= cand_cause_s;
                to_s_r  <= cand_to_s_s;
                pc_r    <= pc_full_s[PC_SZ-1:0];
            end else begin
                cause_r <= cause_r;
                to_s_r  <= to_s_r;
                pc_r    <= pc_r;
            end
        end
    end

    assign irq_valid = valid_r;
    assign irq_cause = cause_r[CAUSE_W-1:0];
    assign irq_to_s  = to_s_r;
    assign trap_pc   = pc_r;

endmodule
